seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. Executes the MIPS function-code operations (add/sub, logic, variable shifts, set-less-than, CLO/CLZ) in one cycle, plus iterative multiply and divide producing HI/LO results. All results and flags are registered behind a valid/ready handshake, so the execute stage can stall on long operations. Sits between the register-read stage and the HI/LO and writeback logic.

## Interface
- WIDTH, 32: operand/result width; even, ≥8.
- SHW, $clog2(WIDTH): shift-amount width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  6  MIPS function code.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts result.
- lo  out  WIDTH  main result / product low / quotient.
- hi  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero_f, neg_f, carry_f, ovf_f, div0_f, err_f  out  1 each  status flags.

## Operation
- Ops: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000100 SLLV, 000110 SRLV, 000111 SRAV (shift b by a[SHW-1:0]), 101010 SLT signed, 101011 SLTU (lo = 1 when a < b), 011100 CLO, 011101 CLZ (count leading ones/zeros of a, 0..WIDTH), 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- Flags: zero_f = (lo == 0); neg_f = lo[WIDTH-1]; carry_f = carry-out for ADDU, borrow for SUBU, else 0; ovf_f = signed overflow for ADD/SUB, else 0.
- Unknown op: lo = hi = 0, err_f = 1, other flags 0, single-cycle.
- MULT/MULTU: shift-add, one bit per cycle; {hi,lo} = full 2·WIDTH product. Signed via magnitude then conditional negate.
- DIV/DIVU: restoring, one bit per cycle; lo = quotient (truncate toward zero), hi = remainder (sign of dividend).
- Divide by zero: lo = all ones, hi = a, div0_f = 1. Signed MIN / -1: lo = MIN, hi = 0, ovf_f = 1. Neither consumes iteration cycles.
- FSM: IDLE → (accept single-cycle op) DONE; IDLE → (accept MUL/DIV) BUSY → after WIDTH iterations DONE; DONE → (out_ready) IDLE, or directly accepts next op if in_valid same cycle.

## Timing
- Accept = in_valid & in_ready at a rising edge; op/a/b sampled then, not needed afterwards.
- in_ready = !reset & (state == IDLE | (state == DONE & out_ready)); 0 in BUSY.
- Single-cycle op accepted at edge N: out_valid high after edge N+1... concretely, out_valid asserted from edge N (registered result) for cycle N+1.
- MUL/DIV accepted at edge N: out_valid asserted after edge N+WIDTH+1 (WIDTH iterations + 1 finalize).
- lo/hi/flags stable while out_valid & !out_ready; out_valid drops the edge after out_ready unless a new result is loaded that edge (back-to-back single-cycle ops: one result per cycle).
- Reset (any time, including mid-iteration): state IDLE, out_valid 0, lo = hi = 0, all flags 0, iteration counter 0; partial results discarded.

## Configuration
- SEQ_ALU_DIV_EN defined: DIV/DIVU implemented as above.
- Not defined: divider hardware omitted; 011010/011011 treated as unknown op (err_f = 1, lo = hi = 0, single-cycle).

## Test plan
- ADD, WIDTH=32, a=32'h7FFFFFFF, b=1 -> lo=32'h80000000, ovf_f=1, neg_f=1, out_valid one cycle after accept.
- SUBU a=0, b=1 -> lo=32'hFFFFFFFF, carry_f=1; CLZ a=32'h00010000 -> lo=15; CLO a=32'hFFFFFFFF -> lo=32.
- MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, out_valid 33 cycles after accept, in_ready 0 throughout.
- DIV a=-7, b=2 -> lo=-3, hi=-1; DIV a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, div0_f=1; DIV 32'h80000000 / -1 -> ovf_f=1.
- Hold out_ready low 5 cycles after ADD result -> lo/flags unchanged, in_ready 0; then back-to-back AND/OR/XOR with out_ready high -> one result per cycle.
- Assert reset at iteration 10 of MULTU -> out_valid 0, lo=hi=0 immediately; next op after deassert completes correctly.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request handshake, result handshake,
// HI/LO results and status flags.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zero_f;
    logic             neg_f;
    logic             carry_f;
    logic             ovf_f;
    logic             div0_f;
    logic             err_f;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, lo, hi, zero_f, neg_f, carry_f, ovf_f, div0_f, err_f
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, lo, hi, zero_f, neg_f, carry_f, ovf_f, div0_f, err_f
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle MIPS-function-code ALU: single-cycle ops plus shift-add multiply and
// restoring divide (divider present only when SEQ_ALU_DIV_EN is defined).
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [5:0] OpAdd  = 6'b100000, OpAddu = 6'b100001, OpSub  = 6'b100010;
    localparam logic [5:0] OpSubu = 6'b100011, OpAnd  = 6'b100100, OpOr   = 6'b100101;
    localparam logic [5:0] OpXor  = 6'b100110, OpNor  = 6'b100111, OpSllv = 6'b000100;
    localparam logic [5:0] OpSrlv = 6'b000110, OpSrav = 6'b000111, OpSlt  = 6'b101010;
    localparam logic [5:0] OpSltu = 6'b101011, OpClo  = 6'b011100, OpClz  = 6'b011101;
    localparam logic [5:0] OpMult = 6'b011000, OpMultu = 6'b011001;
    localparam logic [5:0] OpDiv  = 6'b011010, OpDivu  = 6'b011011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} aluStateT;

    aluStateT         stateQ;
    logic [WIDTH-1:0] loQ, hiQ, accHiQ, accLoQ, opndQ;
    logic             zeroQ, negQ, carryQ, ovfQ, div0Q, errQ, validQ;
    logic             isDivQ, qSignQ, rSignQ;
    logic [CW-1:0]    cntQ;

    logic [5:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             inReady, accept;

    assign op      = bus.op;
    assign a       = bus.a;
    assign b       = bus.b;
    assign inReady = !reset && (stateQ == StIdle || (stateQ == StDone && bus.out_ready));
    assign accept  = bus.in_valid && inReady;

    function automatic logic [WIDTH-1:0] lead0(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) found = 1'b1;
            else if (!found) n = n + WIDTH'(1);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] sLo, sHi, absA, absB;
    logic [WIDTH:0]   sum, diff;
    logic             sCarry, sOvf, sDiv0, sErr, sIter, sIsDiv, sQSign, sRSign, signedOp;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        signedOp = (op == OpMult) || (op == OpDiv);
        absA     = (signedOp && a[WIDTH-1]) ? -a : a;
        absB     = (signedOp && b[WIDTH-1]) ? -b : b;
        sQSign   = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
        sRSign   = signedOp && a[WIDTH-1];
        sLo      = '0;
        sHi      = '0;
        sCarry   = 1'b0;
        sOvf     = 1'b0;
        sDiv0    = 1'b0;
        sErr     = 1'b0;
        sIter    = 1'b0;
        sIsDiv   = 1'b0;
        case (op)
            OpAdd: begin
                sLo  = sum[WIDTH-1:0];
                sOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpAddu: begin
                sLo    = sum[WIDTH-1:0];
                sCarry = sum[WIDTH];
            end
            OpSub: begin
                sLo  = diff[WIDTH-1:0];
                sOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSubu: begin
                sLo    = diff[WIDTH-1:0];
                sCarry = diff[WIDTH];
            end
            OpAnd:  sLo = a & b;
            OpOr:   sLo = a | b;
            OpXor:  sLo = a ^ b;
            OpNor:  sLo = ~(a | b);
            OpSllv: sLo = b << a[SHW-1:0];
            OpSrlv: sLo = b >> a[SHW-1:0];
            OpSrav: sLo = $signed(b) >>> a[SHW-1:0];
            OpSlt:  sLo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OpSltu: sLo = {{(WIDTH-1){1'b0}}, a < b};
            OpClo:  sLo = lead0(~a);
            OpClz:  sLo = lead0(a);
            OpMult, OpMultu: sIter = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OpDiv, OpDivu: begin
                // Both special cases resolve immediately, without iterating.
                if (b == '0) begin
                    sLo   = '1;
                    sHi   = a;
                    sDiv0 = 1'b1;
                end else if (op == OpDiv && a == MinVal && b == '1) begin
                    sLo  = MinVal;
                    sOvf = 1'b1;
                end else begin
                    sIter  = 1'b1;
                    sIsDiv = 1'b1;
                end
            end
`endif
            default: sErr = 1'b1;
        endcase
    end

    logic [WIDTH:0]     mulSum;
    logic [WIDTH-1:0]   iterHi, iterLo, fLo, fHi;
    logic [2*WIDTH-1:0] prod;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divSub;
`endif

    always_comb begin
        // Multiply: accLo holds the multiplier, shifted out LSB-first as product bits arrive.
        mulSum = accLoQ[0] ? ({1'b0, accHiQ} + {1'b0, opndQ}) : {1'b0, accHiQ};
        iterHi = mulSum[WIDTH:1];
        iterLo = {mulSum[0], accLoQ[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        divShift = {accHiQ, accLoQ[WIDTH-1]};
        divSub   = divShift[WIDTH-1:0] - opndQ;
        if (isDivQ) begin
            if (divShift >= {1'b0, opndQ}) begin
                iterHi = divSub;
                iterLo = {accLoQ[WIDTH-2:0], 1'b1};
            end else begin
                iterHi = divShift[WIDTH-1:0];
                iterLo = {accLoQ[WIDTH-2:0], 1'b0};
            end
        end
`endif
        prod = {accHiQ, accLoQ};
        if (qSignQ) prod = -prod;
        fLo = prod[WIDTH-1:0];
        fHi = prod[2*WIDTH-1:WIDTH];
        if (isDivQ) begin
            fLo = qSignQ ? -accLoQ : accLoQ;
            fHi = rSignQ ? -accHiQ : accHiQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            loQ    <= '0;
            hiQ    <= '0;
            accHiQ <= '0;
            accLoQ <= '0;
            opndQ  <= '0;
            cntQ   <= '0;
            zeroQ  <= 1'b0;
            negQ   <= 1'b0;
            carryQ <= 1'b0;
            ovfQ   <= 1'b0;
            div0Q  <= 1'b0;
            errQ   <= 1'b0;
            validQ <= 1'b0;
            isDivQ <= 1'b0;
            qSignQ <= 1'b0;
            rSignQ <= 1'b0;
        end else begin
            case (stateQ)
                StIdle, StDone: begin
                    if (accept && sIter) begin
                        stateQ <= StBusy;
                        validQ <= 1'b0;
                        cntQ   <= '0;
                        accHiQ <= '0;
                        accLoQ <= sIsDiv ? absA : absB;
                        opndQ  <= sIsDiv ? absB : absA;
                        isDivQ <= sIsDiv;
                        qSignQ <= sQSign;
                        rSignQ <= sRSign;
                    end else if (accept) begin
                        stateQ <= StDone;
                        validQ <= 1'b1;
                        loQ    <= sLo;
                        hiQ    <= sHi;
                        zeroQ  <= (sLo == '0) && !sErr;
                        negQ   <= sLo[WIDTH-1];
                        carryQ <= sCarry;
                        ovfQ   <= sOvf;
                        div0Q  <= sDiv0;
                        errQ   <= sErr;
                    end else if (stateQ == StDone && bus.out_ready) begin
                        stateQ <= StIdle;
                        validQ <= 1'b0;
                    end
                end
                StBusy: begin
                    if (cntQ == CW'(WIDTH)) begin
                        stateQ <= StDone;
                        validQ <= 1'b1;
                        cntQ   <= '0;
                        loQ    <= fLo;
                        hiQ    <= fHi;
                        zeroQ  <= (fLo == '0);
                        negQ   <= fLo[WIDTH-1];
                        carryQ <= 1'b0;
                        ovfQ   <= 1'b0;
                        div0Q  <= 1'b0;
                        errQ   <= 1'b0;
                    end else begin
                        accHiQ <= iterHi;
                        accLoQ <= iterLo;
                        cntQ   <= cntQ + CW'(1);
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = validQ;
    assign bus.lo        = loQ;
    assign bus.hi        = hiQ;
    assign bus.zero_f    = zeroQ;
    assign bus.neg_f     = negQ;
    assign bus.carry_f   = carryQ;
    assign bus.ovf_f     = ovfQ;
    assign bus.div0_f    = div0Q;
    assign bus.err_f     = errQ;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, hand-written stall/back-to-back/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, lo, hi;
        logic [5:0]  flags;
        int          lat;
    } vecT;

    typedef struct {
        logic [31:0] lo, hi;
        logic [5:0]  flags;
        int          lat;
    } resT;

    logic [5:0] flagsNow;
    assign flagsNow = {bus.zero_f, bus.neg_f, bus.carry_f, bus.ovf_f, bus.div0_f, bus.err_f};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Result model: {zero, neg, carry, ovf, div0, err}, latency in edges after accept.
    function automatic resT model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        resT                r;
        longint             sa, sb, s;
        logic [63:0]        u;
        logic               carry, ovf, div0, err;
        int                 n;
        r.lo = '0; r.hi = '0; r.lat = 0;
        carry = 1'b0; ovf = 1'b0; div0 = 1'b0; err = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            6'b100000: begin s = sa + sb; r.lo = s[31:0]; ovf = (s != longint'($signed(s[31:0]))); end
            6'b100001: begin u = {32'b0, a} + {32'b0, b}; r.lo = u[31:0]; carry = u[32]; end
            6'b100010: begin s = sa - sb; r.lo = s[31:0]; ovf = (s != longint'($signed(s[31:0]))); end
            6'b100011: begin r.lo = a - b; carry = (a < b); end
            6'b100100: r.lo = a & b;
            6'b100101: r.lo = a | b;
            6'b100110: r.lo = a ^ b;
            6'b100111: r.lo = ~(a | b);
            6'b000100: r.lo = b << a[4:0];
            6'b000110: r.lo = b >> a[4:0];
            6'b000111: r.lo = $signed(b) >>> a[4:0];
            6'b101010: r.lo = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r.lo = (a < b) ? 32'd1 : 32'd0;
            6'b011100, 6'b011101: begin
                n = 0;
                while (n < 32 && a[31-n] == (op == 6'b011100)) n++;
                r.lo = 32'(n);
            end
            6'b011000: begin s = sa * sb; {r.hi, r.lo} = s; r.lat = 33; end
            6'b011001: begin u = {32'b0, a} * {32'b0, b}; {r.hi, r.lo} = u; r.lat = 33; end
`ifdef SEQ_ALU_DIV_EN
            6'b011010: begin
                if (b == 0) begin r.lo = '1; r.hi = a; div0 = 1'b1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r.lo = a; ovf = 1'b1; end
                else begin
                    s = sa / sb; r.lo = s[31:0];
                    s = sa % sb; r.hi = s[31:0];
                    r.lat = 33;
                end
            end
            6'b011011: begin
                if (b == 0) begin r.lo = '1; r.hi = a; div0 = 1'b1; end
                else begin r.lo = a / b; r.hi = a % b; r.lat = 33; end
            end
`endif
            default: err = 1'b1;
        endcase
        r.flags = {(r.lo == 0) && !err, r.lo[31], carry, ovf, div0, err};
        return r;
    endfunction

    logic [31:0] gotLo, gotHi;
    logic [5:0]  gotFlags;
    int          gotLat, busyReady;

    task automatic runOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("acceptWait", 1, 0);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 6'($urandom);
        bus.a  = $urandom;
        bus.b  = $urandom;
        gotLat    = 0;
        busyReady = 0;
        while (!bus.out_valid && gotLat < 200) begin
            if (bus.in_ready) busyReady++;
            @(posedge clk);
            #1;
            gotLat++;
        end
        gotLo    = bus.lo;
        gotHi    = bus.hi;
        gotFlags = flagsNow;
    endtask

    function automatic vecT mkV(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input logic [5:0] flags, input int lat);
        vecT v;
        v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.flags = flags; v.lat = lat;
        return v;
    endfunction

    vecT         vecs[$];
    logic [5:0]  opList[19];
    resT         exp;
    int          holdBad;
    logic [31:0] ra, rb;
    logic [5:0]  rop;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // flags: {zero, neg, carry, ovf, div0, err}
        vecs.push_back(mkV(6'b100000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 6'b010100, 0));
        vecs.push_back(mkV(6'b100011, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 6'b011000, 0));
        vecs.push_back(mkV(6'b011101, 32'h00010000, 32'd0, 32'd15, 0, 6'b000000, 0));
        vecs.push_back(mkV(6'b011100, 32'hFFFFFFFF, 32'd0, 32'd32, 0, 6'b000000, 0));
        vecs.push_back(mkV(6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 6'b010000, 33));
        vecs.push_back(mkV(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 6'b000000, 33));
        vecs.push_back(mkV(6'b100001, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 6'b101000, 0));
        vecs.push_back(mkV(6'b100010, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 6'b000100, 0));
        vecs.push_back(mkV(6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 6'b000000, 0));
        vecs.push_back(mkV(6'b101011, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 6'b100000, 0));
        vecs.push_back(mkV(6'b000111, 32'd4, 32'h80000000, 32'hF8000000, 0, 6'b010000, 0));
        vecs.push_back(mkV(6'b111111, 32'd5, 32'd6, 32'd0, 0, 6'b000001, 0));
`ifdef SEQ_ALU_DIV_EN
        vecs.push_back(mkV(6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 6'b010000, 33));
        vecs.push_back(mkV(6'b011010, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 6'b010010, 0));
        vecs.push_back(mkV(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 6'b010100, 0));
        vecs.push_back(mkV(6'b011011, 32'd100, 32'd7, 32'd14, 32'd2, 6'b000000, 33));
`else
        vecs.push_back(mkV(6'b011010, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 6'b000001, 0));
        vecs.push_back(mkV(6'b011011, 32'd100, 32'd7, 32'd0, 0, 6'b000001, 0));
`endif
        opList = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                   6'b100111, 6'b000100, 6'b000110, 6'b000111, 6'b101010, 6'b101011, 6'b011100,
                   6'b011101, 6'b011000, 6'b011001, 6'b011010, 6'b011011};

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstValid", bus.out_valid, 0);
        check("rstLo", bus.lo, 0);
        check("rstHi", bus.hi, 0);
        check("rstFlags", flagsNow, 0);
        check("rstReady", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("readyAfterRst", bus.in_ready, 1);

        foreach (vecs[i]) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.lo", i), gotLo, vecs[i].lo);
            check($sformatf("vec%0d.hi", i), gotHi, vecs[i].hi);
            check($sformatf("vec%0d.flags", i), gotFlags, vecs[i].flags);
            check($sformatf("vec%0d.lat", i), gotLat, vecs[i].lat);
            check($sformatf("vec%0d.busyReady", i), busyReady, 0);
        end

        // Stall: result must hold while the consumer is not ready.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        runOp(6'b100000, 32'h7FFFFFFF, 32'd1);
        check("holdFirst", gotLo, 32'h80000000);
        holdBad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.lo !== 32'h80000000 || flagsNow !== 6'b010100 || bus.out_valid !== 1'b1
                || bus.in_ready !== 1'b0) holdBad++;
        end
        check("holdStable", holdBad, 0);

        // Back-to-back single-cycle ops: one result per cycle.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 32'hF0F01234;
        bus.b = 32'h0FF0FF00;
        bus.op = 6'b100100;
        @(posedge clk);
        #1;
        check("b2bAndValid", bus.out_valid, 1);
        check("b2bAnd", bus.lo, 32'h00F01200);
        bus.op = 6'b100101;
        @(posedge clk);
        #1;
        check("b2bOr", bus.lo, 32'hFFF0FF34);
        bus.op = 6'b100110;
        @(posedge clk);
        #1;
        check("b2bXor", bus.lo, 32'hFF00ED34);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2bDrain", bus.out_valid, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 6'b011001;
        bus.a  = 32'd12345;
        bus.b  = 32'd6789;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midReadyBusy", bus.in_ready, 0);
        reset = 1'b1;
        #1;
        check("midRstValid", bus.out_valid, 0);
        check("midRstLo", bus.lo, 0);
        check("midRstHi", bus.hi, 0);
        check("midRstFlags", flagsNow, 0);
        @(negedge clk);
        reset = 1'b0;
        runOp(6'b100000, 32'd2, 32'd3);
        check("postRstAdd", gotLo, 32'd5);
        check("postRstAddLat", gotLat, 0);
        runOp(6'b011001, 32'h00010000, 32'h00010000);
        check("postRstMulLo", gotLo, 0);
        check("postRstMulHi", gotHi, 1);
        check("postRstMulFlags", gotFlags, 6'b100000);
        check("postRstMulLat", gotLat, 33);

        // Random ops against the model.
        for (int k = 0; k < 200; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 40) - 20;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 40) - 20;
            if ($urandom_range(0, 15) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else rop = opList[$urandom_range(0, 18)];
            exp = model(rop, ra, rb);
            runOp(rop, ra, rb);
            check($sformatf("rnd%0d op=%b a=%h b=%h lo", k, rop, ra, rb), gotLo, exp.lo);
            check($sformatf("rnd%0d op=%b a=%h b=%h hi", k, rop, ra, rb), gotHi, exp.hi);
            check($sformatf("rnd%0d op=%b flags", k, rop), gotFlags, exp.flags);
            check($sformatf("rnd%0d op=%b lat", k, rop), gotLat, exp.lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
